// File: rtl/scaler_chan_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scaler_chan_n : STAGES-bit tick counter with A/B phase pulses and a
//                 tear-free two-field channel read-out.          Rev 1.0
// ---------------------------------------------------------------------------
module scaler_chan_n #(
  parameter int STAGES  = 33,
  parameter int CW      = 14,
  parameter int LO_BASE = 6,
  parameter int HI_BASE = 20,
  parameter bit SNAP    = 1'b1
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              adv,
  input  logic              clr,
  input  logic              rd_lo_,
  input  logic              rd_hi_,
  output logic [STAGES-1:0] fs,
  output logic [STAGES-1:0] fa,
  output logic [STAGES-1:0] fb,
  output logic [CW-1:0]     chan_lo,
  output logic [CW-1:0]     chan_hi,
  output logic              ovf,
  output logic              ovf_s
);

  localparam logic [STAGES-1:0] C_ONE = {{(STAGES-1){1'b0}}, 1'b1};

  logic [STAGES-1:0] fs_q, fs_d;
  logic [STAGES-1:0] fa_q, fa_d;
  logic [STAGES-1:0] fb_q, fb_d;
  logic              ovf_q, ovf_d;
  logic              ovf_s_q, ovf_s_d;
  logic [CW-1:0]     shadow_q, shadow_d;
  logic              snap_v_q, snap_v_d;
  logic              lo_q, hi_q;
  logic              lo_arm_q, lo_arm_d;
  logic              w_lo_fall;
  logic              w_hi_end;

  always_comb begin
    fs_d     = fs_q;
    ovf_d    = 1'b0;
    ovf_s_d  = ovf_s_q;
    shadow_d = shadow_q;
    snap_v_d = snap_v_q;
    // A strobe held low across reset release is not a fall until it has been seen high.
    lo_arm_d  = lo_arm_q | rd_lo_;
    w_lo_fall = !rd_lo_ && lo_q && lo_arm_q;
    w_hi_end  = rd_hi_ && !hi_q;

    if (clr) begin
      fs_d     = '0;
      ovf_s_d  = 1'b0;
      shadow_d = '0;
      snap_v_d = 1'b0;
    end else begin
      if (adv) begin
        fs_d    = fs_q + C_ONE;
        ovf_d   = &fs_q;
        ovf_s_d = ovf_s_q | (&fs_q);
      end
      // Capture the pre-increment high field so a lo/hi read pair never tears.
      if (w_lo_fall) begin
        shadow_d = fs_q[HI_BASE-1 +: CW];
        snap_v_d = 1'b1;
      end else if (w_hi_end) begin
        snap_v_d = 1'b0;
      end
    end

    fa_d = fs_d & ~fs_q;
    fb_d = ~fs_d & fs_q;
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      fs_q     <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      ovf_q    <= 1'b0;
      ovf_s_q  <= 1'b0;
      shadow_q <= '0;
      snap_v_q <= 1'b0;
      lo_q     <= 1'b1;
      hi_q     <= 1'b1;
      lo_arm_q <= 1'b0;
    end else begin
      fs_q     <= fs_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      ovf_q    <= ovf_d;
      ovf_s_q  <= ovf_s_d;
      shadow_q <= shadow_d;
      snap_v_q <= snap_v_d;
      lo_q     <= rd_lo_;
      hi_q     <= rd_hi_;
      lo_arm_q <= lo_arm_d;
    end
  end

  assign fs    = fs_q;
  assign fa    = fa_q;
  assign fb    = fb_q;
  assign ovf   = ovf_q;
  assign ovf_s = ovf_s_q;

  assign chan_lo = rd_lo_ ? '0 : fs_q[LO_BASE-1 +: CW];
  assign chan_hi = rd_hi_ ? '0 :
                   ((SNAP && snap_v_q) ? shadow_q : fs_q[HI_BASE-1 +: CW]);

endmodule
`default_nettype wire

// File: tb/tb_scaler_chan_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_scaler_chan_n : directed and random checks of two 16-stage scalers
//                    (snapshot on / off) against a count-level model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_scaler_chan_n;

  localparam int ST = 16;
  localparam int CW = 4;
  localparam int LB = 4;
  localparam int HB = 8;
  localparam int unsigned MODV = 65536;

  logic CLOCK = 1'b0;
  logic rst, adv, clr, rd_lo_, rd_hi_;

  logic [ST-1:0] fs_a, fa_a, fb_a, fs_b, fa_b, fb_b;
  logic [CW-1:0] cl_a, ch_a, cl_b, ch_b;
  logic          ovf_a, ovfs_a, ovf_b, ovfs_b;

  int total = 0;
  int bad   = 0;

  // Behavioural model: the count as an integer plus read-protocol bookkeeping.
  int unsigned m_fs, m_fa, m_fb, m_shadow;
  bit          m_ovf, m_ovf_s, m_snap, m_lo_high, m_hi_prev;

  always #5 CLOCK = ~CLOCK;

  scaler_chan_n #(.STAGES(ST), .CW(CW), .LO_BASE(LB), .HI_BASE(HB), .SNAP(1'b1)) u_snap (
    .CLOCK(CLOCK), .rst(rst), .adv(adv), .clr(clr), .rd_lo_(rd_lo_), .rd_hi_(rd_hi_),
    .fs(fs_a), .fa(fa_a), .fb(fb_a), .chan_lo(cl_a), .chan_hi(ch_a),
    .ovf(ovf_a), .ovf_s(ovfs_a));

  scaler_chan_n #(.STAGES(ST), .CW(CW), .LO_BASE(LB), .HI_BASE(HB), .SNAP(1'b0)) u_live (
    .CLOCK(CLOCK), .rst(rst), .adv(adv), .clr(clr), .rd_lo_(rd_lo_), .rd_hi_(rd_hi_),
    .fs(fs_b), .fa(fa_b), .fb(fb_b), .chan_lo(cl_b), .chan_hi(ch_b),
    .ovf(ovf_b), .ovf_s(ovfs_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned field(input int unsigned v, input int base);
    return (v >> (base - 1)) % (1 << CW);
  endfunction

  task automatic model_reset();
    m_fs = 0; m_fa = 0; m_fb = 0; m_shadow = 0;
    m_ovf = 0; m_ovf_s = 0; m_snap = 0;
    m_lo_high = 0;
    m_hi_prev = 1;
  endtask

  task automatic model_edge(input bit a, input bit c, input bit l, input bit h);
    int unsigned nxt;
    bit fall;
    if (c)      nxt = 0;
    else if (a) nxt = (m_fs + 1) % MODV;
    else        nxt = m_fs;
    m_fa  = nxt & ~m_fs & (MODV - 1);
    m_fb  = m_fs & ~nxt & (MODV - 1);
    m_ovf = !c && a && (m_fs == MODV - 1);
    m_ovf_s = c ? 1'b0 : (m_ovf_s | m_ovf);
    fall = !l && m_lo_high;
    if (c) begin
      m_shadow = 0;
      m_snap   = 0;
    end else if (fall) begin
      m_shadow = field(m_fs, HB);
      m_snap   = 1;
    end else if (h && !m_hi_prev) begin
      m_snap = 0;
    end
    m_lo_high = l;
    m_hi_prev = h;
    m_fs = nxt;
  endtask

  task automatic check_chan();
    int unsigned live;
    live = field(m_fs, HB);
    chk("chan_lo_a", cl_a, rd_lo_ ? 0 : field(m_fs, LB));
    chk("chan_lo_b", cl_b, rd_lo_ ? 0 : field(m_fs, LB));
    chk("chan_hi_snap", ch_a, rd_hi_ ? 0 : (m_snap ? m_shadow : live));
    chk("chan_hi_live", ch_b, rd_hi_ ? 0 : live);
  endtask

  task automatic check_state();
    chk("fs_a", fs_a, m_fs);
    chk("fs_b", fs_b, m_fs);
    chk("fa_a", fa_a, m_fa);
    chk("fb_a", fb_a, m_fb);
    chk("fa_b", fa_b, m_fa);
    chk("fb_b", fb_b, m_fb);
    chk("ovf_a", ovf_a, m_ovf);
    chk("ovf_b", ovf_b, m_ovf);
    chk("ovf_s_a", ovfs_a, m_ovf_s);
    chk("ovf_s_b", ovfs_b, m_ovf_s);
  endtask

  task automatic drive(input bit a, input bit c, input bit l, input bit h);
    @(negedge CLOCK);
    adv = a; clr = c; rd_lo_ = l; rd_hi_ = h;
    #1 check_chan();
  endtask

  task automatic edge_step();
    @(posedge CLOCK);
    model_edge(adv, clr, rd_lo_, rd_hi_);
    #1 check_state();
    check_chan();
  endtask

  task automatic cyc(input bit a, input bit c, input bit l, input bit h);
    drive(a, c, l, h);
    edge_step();
  endtask

  initial begin
    rst = 1'b0; adv = 1'b0; clr = 1'b0; rd_lo_ = 1'b1; rd_hi_ = 1'b1;
    model_reset();
    #12;
    check_state();
    check_chan();
    @(negedge CLOCK);
    rst = 1'b1;

    // count up and phase pulses
    repeat (5) cyc(1, 0, 1, 1);
    chk("fs_after_5", fs_a, 5);
    repeat (4) cyc(1, 0, 1, 1);
    cyc(1, 1, 1, 1);
    chk("clr9_fb", fb_a, 16'h0009);
    chk("clr9_fa", fa_a, 0);

    // low-read fall on the carry edge
    repeat (127) cyc(1, 0, 1, 1);
    drive(1, 0, 0, 1);
    chk("lo_at_fall", cl_a, 4'hF);
    edge_step();
    cyc(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    chk("hi_snapshot", ch_a, 0);
    chk("hi_live", ch_b, 1);
    edge_step();
    drive(0, 0, 0, 1);
    chk("hi_idle", ch_b, 0);
    edge_step();

    // clr while low strobe held drops the snapshot
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    repeat (128) cyc(1, 0, 0, 1);
    drive(0, 0, 0, 0);
    chk("hi_shadow_held", ch_a, 1);
    edge_step();
    cyc(0, 1, 0, 0);
    repeat (128) cyc(1, 0, 0, 0);
    chk("hi_live_after_clr", ch_a, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60);
    end

    // full wrap
    cyc(0, 1, 1, 1);
    for (int i = 0; i < 65535; i++) cyc(1, 0, 1, 1);
    chk("all_ones", fs_a, 16'hFFFF);
    cyc(1, 0, 1, 1);
    chk("wrap_fs", fs_a, 0);
    chk("wrap_ovf", ovf_a, 1);
    chk("wrap_fb", fb_a, 16'hFFFF);
    cyc(0, 0, 1, 1);
    chk("ovf_one_cycle", ovf_a, 0);
    chk("ovf_s_held", ovfs_a, 1);
    cyc(0, 1, 1, 1);
    chk("ovf_s_cleared", ovfs_a, 0);

    // reset in the middle of a high read with a live snapshot
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    repeat (300) cyc(1, 0, 0, 1);
    drive(0, 0, 0, 0);
    edge_step();
    #2 rst = 1'b0;
    #1;
    chk("rst_fs", fs_a, 0);
    chk("rst_chan_lo", cl_a, 0);
    chk("rst_chan_hi", ch_a, 0);
    model_reset();
    check_state();
    check_chan();
    @(negedge CLOCK);
    rst = 1'b1;
    edge_step();
    repeat (144) cyc(1, 0, 0, 0);
    chk("no_snap_after_rst", ch_a, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    repeat (128) cyc(1, 0, 0, 0);
    chk("resnap_shadow", ch_a, 1);
    chk("resnap_live", ch_b, 2);
    repeat (3) cyc(0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
